// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port data RAM among NUM_CORES cores,
// fixed 2-cycle read latency, sticky completion tracking. Optional DMEM_ARB_STATS_EN adds stall_count.
// state  | meaning
// RUN    | arbitrating; collecting per-core end flags
// DRAIN  | every core ended; waiting for in-flight reads to return
// DONE   | all_done raised; requests ignored until reset
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  input  logic [NUM_CORES-1:0]          core_end,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [NUM_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]                   stall_count,
`endif
  output logic                          all_done
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NUM_CORES-1:0]   end_flag;
  logic [NUM_CORES-1:0]   eligible;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       ptr_nxt;
  logic [PTR_W:0]         idx;
  logic                   found;
  logic [NUM_CORES-1:0]   win_oh;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [NUM_CORES-1:0]   rd_s1;
  logic [NUM_CORES-1:0]   rd_s2;

  // A core ending in the same cycle it requests is already masked.
  assign eligible = (state == ST_RUN) ? (core_req & ~(end_flag | core_end)) : '0;

  always_comb begin
    win_oh  = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_CORES)) idx = idx - (PTR_W+1)'(NUM_CORES);
      if (!found && eligible[idx[PTR_W-1:0]]) begin
        found                    = 1'b1;
        win_oh[idx[PTR_W-1:0]]   = 1'b1;
        ptr_nxt = (idx[PTR_W-1:0] == PTR_W'(NUM_CORES - 1)) ? '0
                                                            : idx[PTR_W-1:0] + PTR_W'(1);
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (win_oh[n]) begin
        sel_we    = core_we[n];
        sel_addr  = core_addr[n*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[n*DATA_W +: DATA_W];
      end
    end
  end

  // rd_s1 tracks the RAM address cycle, rd_s2 the RAM data cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      core_gnt    <= '0;
      core_rvalid <= '0;
      core_rdata  <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ptr         <= '0;
      end_flag    <= '0;
      rd_s1       <= '0;
      rd_s2       <= '0;
    end else begin
      core_gnt <= win_oh;
      ram_we   <= found & sel_we;
      if (found) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
        ptr       <= ptr_nxt;
      end
      rd_s1       <= sel_we ? '0 : win_oh;
      rd_s2       <= rd_s1;
      core_rvalid <= rd_s2;
      if (|rd_s2) core_rdata <= ram_rdata;
      if (state == ST_RUN) end_flag <= end_flag | core_end;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (&(end_flag | core_end)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!(|{rd_s1, rd_s2}))     state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign all_done = (state == ST_DONE);

`ifdef DMEM_ARB_STATS_EN
  // Counts cycles where some eligible core lost arbitration.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if ((state != ST_DONE) && ($countones(eligible) > 1) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + randomized traffic against a behavioural reference model;
// expected grants/read returns are queued by the stimulus and consumed by a separate monitor.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int M_DROP = 0;
  localparam int M_RAND = 1;
  localparam int M_HOLD = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    core_req = '0;
  logic [N-1:0]    core_we = '0;
  logic [N*AW-1:0] core_addr = '0;
  logic [N*DW-1:0] core_wdata = '0;
  logic [N-1:0]    core_end = '0;
  logic [N-1:0]    core_gnt;
  logic [N-1:0]    core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata = '0;
  logic            all_done;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]     stall_count;
`endif

  always #5 clock = ~clock;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_end    (core_end),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stall_count (stall_count),
`endif
    .all_done    (all_done)
  );

  // Synchronous single-port RAM, one cycle read latency.
  logic [DW-1:0] ram_mem [256];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  typedef struct {
    int            stamp;
    int            core;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } gnt_t;
  typedef struct {
    int            stamp;
    int            core;
    logic [DW-1:0] data;
  } rd_t;

  gnt_t exp_g[$];
  rd_t  exp_r[$];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          finish_req = 1'b0;
  int            ptr_m = 0;
  logic [N-1:0]  endf_m = '0;
  logic          ended_m = 1'b0;
  int            last_rd = 0;
  int            done_at = 1 << 30;
  logic [15:0]   stall_m = '0;
  int            mode = M_DROP;
  logic [DW-1:0] ref_mem [256];

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: the only process that compares and counts.
  always @(posedge clock) begin : monitor
    gnt_t          g;
    rd_t           r;
    logic [N-1:0]  oh;
    logic [AW-1:0] hold_addr;
    #1;
    if (reset) begin
      checks++;
      if (core_gnt !== '0 || core_rvalid !== '0 || ram_we !== 1'b0 || ram_addr !== '0 ||
          ram_wdata !== '0 || core_rdata !== '0 || all_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d gnt=%b rvalid=%b we=%b addr=%h wdata=%h rdata=%h done=%b required all zero",
                 cyc, core_gnt, core_rvalid, ram_we, ram_addr, ram_wdata, core_rdata, all_done);
      end
      exp_g.delete();
      exp_r.delete();
      hold_addr = '0;
    end else begin
      checks++;
      if (all_done !== (cyc >= done_at)) begin
        errors++;
        $display("FAIL all_done cyc=%0d got=%b required=%b", cyc, all_done, (cyc >= done_at));
      end
      if (core_gnt !== '0) begin
        checks++;
        if (exp_g.size() == 0) begin
          errors++;
          $display("FAIL unexpected_gnt cyc=%0d got=%b required=none", cyc, core_gnt);
        end else begin
          g = exp_g.pop_front();
          oh = '0;
          oh[g.core] = 1'b1;
          if (core_gnt !== oh || g.stamp != cyc || ram_we !== g.we || ram_addr !== g.addr ||
              (g.we && ram_wdata !== g.data)) begin
            errors++;
            $display("FAIL grant cyc=%0d got gnt=%b we=%b addr=%h wdata=%h required cyc=%0d gnt=%b we=%b addr=%h wdata=%h",
                     cyc, core_gnt, ram_we, ram_addr, ram_wdata, g.stamp, oh, g.we, g.addr, g.data);
          end
          hold_addr = g.addr;
        end
      end else begin
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== hold_addr) begin
          errors++;
          $display("FAIL idle_ram cyc=%0d got we=%b addr=%h required we=0 addr=%h", cyc, ram_we, ram_addr, hold_addr);
        end
        if (exp_g.size() > 0 && exp_g[0].stamp <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_gnt cyc=%0d got=none required core %0d at cyc %0d", cyc, exp_g[0].core, exp_g[0].stamp);
          void'(exp_g.pop_front());
        end
      end
      if (core_rvalid !== '0) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid cyc=%0d got=%b required=none", cyc, core_rvalid);
        end else begin
          r = exp_r.pop_front();
          oh = '0;
          oh[r.core] = 1'b1;
          if (core_rvalid !== oh || r.stamp != cyc || core_rdata !== r.data) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got rvalid=%b rdata=%h required cyc=%0d rvalid=%b rdata=%h",
                     cyc, core_rvalid, core_rdata, r.stamp, oh, r.data);
          end
        end
      end else if (exp_r.size() > 0 && exp_r[0].stamp <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid cyc=%0d got=none required core %0d at cyc %0d", cyc, exp_r[0].core, exp_r[0].stamp);
        void'(exp_r.pop_front());
      end
    end
`ifdef DMEM_ARB_STATS_EN
    checks++;
    if (stall_count !== stall_m) begin
      errors++;
      $display("FAIL stall_count cyc=%0d got=%0d required=%0d", cyc, stall_count, stall_m);
    end
`endif
    if (finish_req) begin
      checks++;
      if (exp_g.size() != 0 || exp_r.size() != 0) begin
        errors++;
        $display("FAIL leftover got gnt_q=%0d rd_q=%0d required 0 0", exp_g.size(), exp_r.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic new_req(int c);
    core_req[c]               = 1'b1;
    core_we[c]                = 1'($urandom_range(0, 1));
    core_addr[c*AW +: AW]     = AW'($urandom_range(0, 15));
    core_wdata[c*DW +: DW]    = DW'($urandom);
  endtask

  task automatic set_req(int c, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    core_req[c]            = 1'b1;
    core_we[c]             = we;
    core_addr[c*AW +: AW]  = a;
    core_wdata[c*DW +: DW] = d;
  endtask

  task automatic refresh(int w);
    if (mode != M_HOLD) begin
      for (int c = 0; c < N; c++) begin
        if (c == w) begin
          if (mode == M_RAND && $urandom_range(0, 1) == 1) new_req(c);
          else core_req[c] = 1'b0;
        end else if (mode == M_RAND && !core_req[c] && $urandom_range(0, 2) == 0) begin
          new_req(c);
        end
      end
    end
  endtask

  // Reference model for the upcoming edge: round robin from ptr_m over unfinished requesters.
  task automatic step();
    logic [N-1:0] elig;
    int           w;
    gnt_t         g;
    rd_t          r;
    elig = core_req & ~(endf_m | core_end);
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && elig[(ptr_m + k) % N]) w = (ptr_m + k) % N;
    end
    if ($countones(elig) > 1 && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
    if (w >= 0) begin
      g.stamp = cyc + 1;
      g.core  = w;
      g.we    = core_we[w];
      g.addr  = core_addr[w*AW +: AW];
      g.data  = core_wdata[w*DW +: DW];
      exp_g.push_back(g);
      if (g.we) begin
        ref_mem[g.addr] = g.data;
      end else begin
        r.stamp = cyc + 3;
        r.core  = w;
        r.data  = ref_mem[g.addr];
        exp_r.push_back(r);
        last_rd = r.stamp;
      end
      ptr_m = (w + 1) % N;
    end
    if (!ended_m) begin
      endf_m = endf_m | core_end;
      if (&endf_m) begin
        ended_m = 1'b1;
        done_at = (cyc + 2 > last_rd + 1) ? cyc + 2 : last_rd + 1;
      end
    end
    @(posedge clock);
    @(negedge clock);
    refresh(w);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    core_req = '0;
    core_end = '0;
    core_we  = '0;
    ptr_m    = 0;
    endf_m   = '0;
    ended_m  = 1'b0;
    last_rd  = 0;
    done_at  = 1 << 30;
    stall_m  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
    end
    do_reset();

    // Core 0 write then read-back of the same word.
    mode = M_DROP;
    set_req(0, 1'b1, 8'h10, 16'hBEEF);
    step();
    set_req(0, 1'b0, 8'h10, 16'h0000);
    step();
    repeat (3) step();

    // All cores requesting every cycle from reset.
    do_reset();
    mode = M_HOLD;
    for (int c = 0; c < N; c++) set_req(c, 1'b0, AW'(8'h20 + c), '0);
    repeat (6) step();
    core_req = '0;
    mode = M_DROP;
    repeat (3) step();

    // Pointer at 2 after a core-1 grant, then cores 1 and 3 contend.
    do_reset();
    set_req(1, 1'b0, 8'h21, '0);
    step();
    set_req(1, 1'b1, 8'h31, 16'h1111);
    set_req(3, 1'b1, 8'h33, 16'h3333);
    repeat (4) step();

    // Core 2 ends while requesting; others keep running.
    mode = M_RAND;
    for (int c = 0; c < N; c++) new_req(c);
    core_end = 4'b0100;
    step();
    core_end = '0;
    repeat (300) step();

    // Quiesce, then end cores 0, 1 and finally 3 with a read in flight.
    mode = M_DROP;
    repeat (8) step();
    core_req = '0;
    step();
    core_end = 4'b0001;
    step();
    core_end = '0;
    step();
    core_end = 4'b0010;
    step();
    core_end = '0;
    set_req(3, 1'b0, 8'h10, '0);
    step();
    core_end = 4'b1000;
    step();
    core_end = '0;
    mode = M_RAND;
    for (int c = 0; c < N; c++) new_req(c);
    repeat (8) step();

    // Reset one cycle after a read grant, then 10 cycles of full contention.
    do_reset();
    mode = M_DROP;
    set_req(0, 1'b0, 8'h10, '0);
    step();
    do_reset();
    repeat (3) step();
    mode = M_HOLD;
    for (int c = 0; c < N; c++) set_req(c, 1'b0, AW'(c * 3), '0);
    repeat (10) step();
    core_req = '0;
    mode = M_DROP;
    repeat (4) step();

    finish_req = 1'b1;
    repeat (4) @(posedge clock);
    $display("FAIL finish_timeout monitor did not end the run");
    $fatal(1, "monitor did not finish");
  end

endmodule
